// File: rtl/uart_rx_cmd_dispatcher_if.sv
// ---------------------------------------------------------------------------
// uart_rx_cmd_dispatcher_if
// Byte handshake between the uart receiver and the command dispatcher.
//   rx_ready  : uart -> dispatcher, a received byte is available
//   rx_data   : uart -> dispatcher, received byte (bit 7 is not used)
//   rx_clear  : dispatcher -> uart, one-cycle pulse that clears rx_ready
// Modports:
//   master : uart side (drives rx_ready/rx_data, sees rx_clear)
//   slave  : dispatcher side
// ---------------------------------------------------------------------------
interface uart_rx_cmd_dispatcher_if;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_clear;

  modport master (output rx_ready, output rx_data, input rx_clear);
  modport slave  (input rx_ready, input rx_data, output rx_clear);
endinterface

// File: rtl/uart_rx_cmd_dispatcher.sv
// ---------------------------------------------------------------------------
// uart_rx_cmd_dispatcher
// Sole consumer of the uart receive port. Parses framed commands
//   <hdr> <sign> <mag> [<chk>]
// where hdr selects the left ('L'), right ('R') or enable ('I') setpoint pair,
// sign is '+', '-' or '0' and mag is a 7-bit magnitude. Each received byte is
// acknowledged with exactly one rx_clear pulse. A completed frame updates the
// selected RPM/DIR pair and pulses its upd strobe; a bad sign, a bad checksum
// or an inter-byte timeout mid-frame pulses frame_err and discards the frame.
//
// Optional feature: define RX_CHECKSUM_EN to require a fourth checksum byte
// (chk[6:0] == hdr ^ sign ^ mag over 7 bits). Without it frames are 3 bytes.
//
// Ports:
//   FPGA_CLK1_50      in   system clock
//   RST               in   asynchronous reset, active-high
//   rx_if             slave byte handshake (rx_ready, rx_data, rx_clear)
//   RPM_L/R/ENABLE    out  held magnitudes {1'b0, mag[6:0]}
//   DIR_L/R/ENABLE    out  held direction 01=+1, 11=-1, 00=0
//   upd_L/R/I         out  one-cycle pulse when the matching pair updates
//   frame_err         out  one-cycle pulse on a rejected frame
//   busy              out  high while a frame is in progress
//
// FSM states:
//   state  | meaning
//   S_HDR  | idle, waiting for a header byte; other bytes dropped silently
//   S_SIGN | header latched, waiting for the sign byte
//   S_MAG  | sign latched, waiting for the magnitude byte
//   S_CHK  | magnitude latched, waiting for the checksum (RX_CHECKSUM_EN)
// ---------------------------------------------------------------------------
module uart_rx_cmd_dispatcher #(
  parameter int unsigned TIMEOUT_CYC = 500000,
  parameter logic [7:0]  HDR_L       = 8'd76,
  parameter logic [7:0]  HDR_R       = 8'd82,
  parameter logic [7:0]  HDR_I       = 8'd73
) (
  input  logic                             FPGA_CLK1_50,
  input  logic                             RST,
  uart_rx_cmd_dispatcher_if.slave          rx_if,
  output logic [7:0]                       RPM_L,
  output logic [1:0]                       DIR_L,
  output logic [7:0]                       RPM_R,
  output logic [1:0]                       DIR_R,
  output logic [7:0]                       RPM_ENABLE,
  output logic [1:0]                       DIR_ENABLE,
  output logic                             upd_L,
  output logic                             upd_R,
  output logic                             upd_I,
  output logic                             frame_err,
  output logic                             busy
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  localparam logic [7:0] CH_PLUS  = 8'd43;
  localparam logic [7:0] CH_MINUS = 8'd45;
  localparam logic [7:0] CH_ZERO  = 8'd48;

`ifdef RX_CHECKSUM_EN
  typedef enum logic [1:0] {S_HDR, S_SIGN, S_MAG, S_CHK} state_t;
`else
  typedef enum logic [1:0] {S_HDR, S_SIGN, S_MAG} state_t;
`endif

  typedef enum logic [1:0] {CH_L, CH_R, CH_I} chan_t;

  state_t        state_q, state_d;
  chan_t         chan_q, chan_d;
  logic [1:0]    dir_q, dir_d;
  logic          armed_q, armed_d;
  logic          rx_clear_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [7:0]    rpm_l_q, rpm_l_d, rpm_r_q, rpm_r_d, rpm_i_q, rpm_i_d;
  logic [1:0]    dir_l_q, dir_l_d, dir_r_q, dir_r_d, dir_i_q, dir_i_d;
  logic          upd_l_q, upd_l_d, upd_r_q, upd_r_d, upd_i_q, upd_i_d;
  logic          ferr_q, ferr_d;

`ifdef RX_CHECKSUM_EN
  logic [6:0]    mag_q, mag_d;
  logic [6:0]    csum_q, csum_d;
`endif

  logic          accept;
  logic          in_frame;
  logic          timeout;
  logic [7:0]    b;
  logic          commit;
  logic [6:0]    commit_mag;
  logic          unused_rx_bit7;

  // rx_clear_q in the term blocks a second accept while the uart is still
  // seeing its clear; armed blocks repeats while rx_ready is held high late.
  assign accept         = rx_if.rx_ready & armed_q & ~rx_clear_q;
  assign b              = {1'b0, rx_if.rx_data[6:0]};
  assign unused_rx_bit7 = rx_if.rx_data[7];
  assign in_frame       = (state_q != S_HDR);
  assign timeout        = in_frame & (cnt_q == TO_LAST) & ~accept;

  // Handshake and timeout counter
  always_comb begin
    armed_d = armed_q;
    if (accept)
      armed_d = 1'b0;
    else if (!rx_if.rx_ready)
      armed_d = 1'b1;

    cnt_d = cnt_q;
    if (accept || !in_frame)
      cnt_d = '0;
    else if (cnt_q != TO_LAST)
      cnt_d = cnt_q + CW'(1);
  end

  // Frame FSM next-state and output logic
  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    dir_d      = dir_q;
    rpm_l_d    = rpm_l_q;
    rpm_r_d    = rpm_r_q;
    rpm_i_d    = rpm_i_q;
    dir_l_d    = dir_l_q;
    dir_r_d    = dir_r_q;
    dir_i_d    = dir_i_q;
    upd_l_d    = 1'b0;
    upd_r_d    = 1'b0;
    upd_i_d    = 1'b0;
    ferr_d     = 1'b0;
    commit     = 1'b0;
    commit_mag = b[6:0];
`ifdef RX_CHECKSUM_EN
    mag_d      = mag_q;
    csum_d     = csum_q;
`endif

    case (state_q)
      S_HDR: begin
        if (accept) begin
          if (b == HDR_L) begin
            chan_d  = CH_L;
            state_d = S_SIGN;
          end else if (b == HDR_R) begin
            chan_d  = CH_R;
            state_d = S_SIGN;
          end else if (b == HDR_I) begin
            chan_d  = CH_I;
            state_d = S_SIGN;
          end
`ifdef RX_CHECKSUM_EN
          csum_d = b[6:0];
`endif
        end
      end

      S_SIGN: begin
        if (accept) begin
          state_d = S_MAG;
          case (b)
            CH_PLUS:  dir_d = 2'b01;
            CH_MINUS: dir_d = 2'b11;
            CH_ZERO:  dir_d = 2'b00;
            default: begin
              ferr_d  = 1'b1;
              state_d = S_HDR;
            end
          endcase
`ifdef RX_CHECKSUM_EN
          csum_d = csum_q ^ b[6:0];
`endif
        end
      end

      S_MAG: begin
        if (accept) begin
`ifdef RX_CHECKSUM_EN
          mag_d   = b[6:0];
          csum_d  = csum_q ^ b[6:0];
          state_d = S_CHK;
`else
          commit     = 1'b1;
          commit_mag = b[6:0];
          state_d    = S_HDR;
`endif
        end
      end

`ifdef RX_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          state_d = S_HDR;
          if (b[6:0] == csum_q) begin
            commit     = 1'b1;
            commit_mag = mag_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
`endif

      default: state_d = S_HDR;
    endcase

    // Timeout only fires without an accept, so it never races a commit.
    if (timeout) begin
      state_d = S_HDR;
      ferr_d  = 1'b1;
    end

    if (commit) begin
      case (chan_q)
        CH_L: begin
          rpm_l_d = {1'b0, commit_mag};
          dir_l_d = dir_q;
          upd_l_d = 1'b1;
        end
        CH_R: begin
          rpm_r_d = {1'b0, commit_mag};
          dir_r_d = dir_q;
          upd_r_d = 1'b1;
        end
        CH_I: begin
          rpm_i_d = {1'b0, commit_mag};
          dir_i_d = dir_q;
          upd_i_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge FPGA_CLK1_50 or posedge RST) begin
    if (RST) begin
      state_q    <= S_HDR;
      chan_q     <= CH_L;
      dir_q      <= 2'b00;
      armed_q    <= 1'b0;
      rx_clear_q <= 1'b0;
      cnt_q      <= '0;
      rpm_l_q    <= '0;
      rpm_r_q    <= '0;
      rpm_i_q    <= '0;
      dir_l_q    <= 2'b00;
      dir_r_q    <= 2'b00;
      dir_i_q    <= 2'b00;
      upd_l_q    <= 1'b0;
      upd_r_q    <= 1'b0;
      upd_i_q    <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef RX_CHECKSUM_EN
      mag_q      <= '0;
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      dir_q      <= dir_d;
      armed_q    <= armed_d;
      rx_clear_q <= accept;
      cnt_q      <= cnt_d;
      rpm_l_q    <= rpm_l_d;
      rpm_r_q    <= rpm_r_d;
      rpm_i_q    <= rpm_i_d;
      dir_l_q    <= dir_l_d;
      dir_r_q    <= dir_r_d;
      dir_i_q    <= dir_i_d;
      upd_l_q    <= upd_l_d;
      upd_r_q    <= upd_r_d;
      upd_i_q    <= upd_i_d;
      ferr_q     <= ferr_d;
`ifdef RX_CHECKSUM_EN
      mag_q      <= mag_d;
      csum_q     <= csum_d;
`endif
    end
  end

  assign rx_if.rx_clear = rx_clear_q;
  assign RPM_L          = rpm_l_q;
  assign RPM_R          = rpm_r_q;
  assign RPM_ENABLE     = rpm_i_q;
  assign DIR_L          = dir_l_q;
  assign DIR_R          = dir_r_q;
  assign DIR_ENABLE     = dir_i_q;
  assign upd_L          = upd_l_q;
  assign upd_R          = upd_r_q;
  assign upd_I          = upd_i_q;
  assign frame_err      = ferr_q;
  assign busy           = in_frame;

endmodule

// File: tb/tb_uart_rx_cmd_dispatcher.sv
module tb_uart_rx_cmd_dispatcher;

  localparam int unsigned T = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_cmd_dispatcher_if rx_if();

  logic [7:0] RPM_L, RPM_R, RPM_ENABLE;
  logic [1:0] DIR_L, DIR_R, DIR_ENABLE;
  logic       upd_L, upd_R, upd_I, frame_err, busy;

  uart_rx_cmd_dispatcher #(.TIMEOUT_CYC(T)) dut (
    .FPGA_CLK1_50(clk),
    .RST(rst),
    .rx_if(rx_if),
    .RPM_L(RPM_L),
    .DIR_L(DIR_L),
    .RPM_R(RPM_R),
    .DIR_R(DIR_R),
    .RPM_ENABLE(RPM_ENABLE),
    .DIR_ENABLE(DIR_ENABLE),
    .upd_L(upd_L),
    .upd_R(upd_R),
    .upd_I(upd_I),
    .frame_err(frame_err),
    .busy(busy)
  );

  // kind: 0/1/2 = update L/R/I, 3 = frame_err on a byte, 4 = timeout frame_err
  typedef struct packed {
    logic [2:0]  kind;
    logic [23:0] rpm;
    logic [5:0]  dir;
  } ev_t;

  ev_t        exp_q[$];
  logic [6:0] fbuf[$];
  logic [7:0] m_rpm[3];
  logic [1:0] m_dir[3];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         n_sent = 0;
  int         n_clr = 0;
  int         last_hold = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int hdr_idx(input logic [6:0] v);
    if (v == 7'd76) return 0;
    if (v == 7'd82) return 1;
    if (v == 7'd73) return 2;
    return -1;
  endfunction

  function automatic logic is_sign(input logic [6:0] v);
    return (v == 7'd43) || (v == 7'd45) || (v == 7'd48);
  endfunction

  task automatic push_ev(input logic [2:0] k);
    ev_t e;
    e.kind = k;
    e.rpm  = {m_rpm[0], m_rpm[1], m_rpm[2]};
    e.dir  = {m_dir[0], m_dir[1], m_dir[2]};
    exp_q.push_back(e);
  endtask

  task automatic model_commit(input logic [6:0] h, input logic [6:0] s, input logic [6:0] m);
    int ch;
    ch = hdr_idx(h);
    m_rpm[ch] = {1'b0, m};
    m_dir[ch] = (s == 7'd43) ? 2'b01 : (s == 7'd45) ? 2'b11 : 2'b00;
    push_ev(3'(ch));
  endtask

  task automatic model_byte(input logic [7:0] raw);
    logic [6:0] v;
    v = raw[6:0];
    if (fbuf.size() == 0) begin
      if (hdr_idx(v) >= 0) fbuf.push_back(v);
    end else if (fbuf.size() == 1) begin
      if (is_sign(v)) fbuf.push_back(v);
      else begin
        push_ev(3'd3);
        fbuf.delete();
      end
    end else if (fbuf.size() == 2) begin
`ifdef RX_CHECKSUM_EN
      fbuf.push_back(v);
`else
      model_commit(fbuf[0], fbuf[1], v);
      fbuf.delete();
`endif
    end else begin
      if ((fbuf[0] ^ fbuf[1] ^ fbuf[2]) == v) model_commit(fbuf[0], fbuf[1], fbuf[2]);
      else push_ev(3'd3);
      fbuf.delete();
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_rpm[i] = 8'd0;
      m_dir[i] = 2'b00;
    end
    fbuf.delete();
    last_hold = 0;
  endtask

  // ---------------- uart-side driver ----------------
  // Accept-to-accept spacing is hold + gap + 2 clocks; a frame in progress
  // survives a spacing of up to T clocks.
  task automatic idle(input int g);
    if (fbuf.size() != 0 && (last_hold + g + 2) > int'(T)) begin
      push_ev(3'd4);
      fbuf.delete();
    end
    repeat (g) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v, input int hold);
    logic got;
    #1;
    rx_if.rx_ready = 1'b1;
    rx_if.rx_data  = v;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      if (rx_if.rx_clear) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL handshake: no rx_clear for byte %h, expected a pulse", v);
    end else begin
      n_sent++;
      model_byte(v);
    end
    repeat (hold) @(posedge clk);
    @(posedge clk);
    #1;
    rx_if.rx_ready = 1'b0;
    last_hold = hold;
  endtask

  task automatic sb(input logic [7:0] v, input int hold);
    idle(1 + int'($urandom % 4));
    send_byte(v, hold);
  endtask

  task automatic frame(input logic [7:0] h, input logic [7:0] s, input logic [7:0] m, input int hold);
    sb(h, hold);
    sb(s, hold);
    sb(m, hold);
`ifdef RX_CHECKSUM_EN
    sb({1'b0, h[6:0] ^ s[6:0] ^ m[6:0]}, hold);
`endif
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      logic [3:0] p;
      logic [2:0] ak;
      ev_t        e;
      if (rx_if.rx_clear) n_clr++;
      p = {frame_err, upd_I, upd_R, upd_L};
      if (p != 4'b0000) begin
        case (p)
          4'b0001: ak = 3'd0;
          4'b0010: ak = 3'd1;
          4'b0100: ak = 3'd2;
          4'b1000: ak = rx_if.rx_clear ? 3'd3 : 3'd4;
          default: ak = 3'd7;
        endcase
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL event: got kind=%0d with none expected", ak);
        end else begin
          e = exp_q.pop_front();
          if ({ak, RPM_L, RPM_R, RPM_ENABLE, DIR_L, DIR_R, DIR_ENABLE, busy, rx_if.rx_clear} !==
              {e.kind, e.rpm, e.dir, 1'b0, (e.kind != 3'd4)}) begin
            n_fail++;
            $display("FAIL event: got kind=%0d rpm=%h dir=%h busy=%b clr=%b, expected kind=%0d rpm=%h dir=%h busy=0 clr=%b",
                     ak, {RPM_L, RPM_R, RPM_ENABLE}, {DIR_L, DIR_R, DIR_ENABLE}, busy, rx_if.rx_clear,
                     e.kind, e.rpm, e.dir, (e.kind != 3'd4));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] h, s, m, x;
    int r, hold;
    rx_if.rx_ready = 1'b0;
    rx_if.rx_data  = 8'h00;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {RPM_L, RPM_R, RPM_ENABLE, DIR_L, DIR_R, DIR_ENABLE, upd_L, upd_R, upd_I,
                          frame_err, busy, rx_if.rx_clear}, 64'd0);
    rst = 1'b0;
    idle(2);

    // directed cases
    frame("L", "+", 8'h64, 0);
    frame("R", "-", 8'h32, 0);
    sb("X", 0);
    frame("I", "0", 8'h3F, 0);
    sb("L", 0); sb("+", 0);
    idle(T + 10);
    check("busy_after_timeout", busy, 1'b0);
    frame("L", "-", 8'h0A, 0);
    sb("L", 0); sb("*", 0);
    frame(8'hD2, "+", 8'h01, 5);

    // timeout boundary: spacing of exactly T survives, T+1 does not
    sb("R", 0); sb("+", 0);
    idle(T - 2);
    send_byte(8'h11, 0);
`ifdef RX_CHECKSUM_EN
    sb({1'b0, 7'd82 ^ 7'd43 ^ 7'h11}, 0);
`endif
    sb("I", 0); sb("-", 0);
    idle(T - 1);
    send_byte(8'h05, 0);

`ifdef RX_CHECKSUM_EN
    sb("L", 0); sb("+", 0); sb(8'h64, 0); sb(8'h00, 0);
    sb("L", 0); sb("+", 0); sb(8'h64, 0); sb(8'h04, 0);
`endif

    // reset in the middle of a frame
    sb("L", 0); sb("+", 0);
    repeat (3) @(posedge clk);
    #1;
    check("busy_mid_frame", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_mid_frame", {RPM_L, RPM_R, RPM_ENABLE, DIR_L, DIR_R, DIR_ENABLE, upd_L, upd_R,
                                    upd_I, frame_err, busy, rx_if.rx_clear}, 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    frame("R", "+", 8'h07, 0);

    // randomized traffic
    for (int it = 0; it < 150; it++) begin
      r    = int'($urandom % 10);
      hold = ($urandom % 4 == 0) ? int'($urandom % 4) : 0;
      case (($urandom % 3))
        0: h = "L";
        1: h = "R";
        default: h = "I";
      endcase
      case (($urandom % 3))
        0: s = "+";
        1: s = "-";
        default: s = "0";
      endcase
      h[7] = $urandom % 2;
      s[7] = $urandom % 2;
      m    = 8'($urandom);
      if (r <= 5) begin
        frame(h, s, m, hold);
      end else if (r == 6) begin
        do x = 8'($urandom); while (hdr_idx(x[6:0]) >= 0);
        sb(x, hold);
      end else if (r == 7) begin
        do x = 8'($urandom); while (is_sign(x[6:0]));
        sb(h, hold); sb(x, hold);
      end else if (r == 8) begin
        sb(h, 0);
        if ($urandom % 2) sb(s, 0);
        idle(T + 5);
      end else begin
`ifdef RX_CHECKSUM_EN
        sb(h, hold); sb(s, hold); sb(m, hold);
        sb({1'b0, (h[6:0] ^ s[6:0] ^ m[6:0]) ^ 7'(1 + $urandom % 127)}, hold);
`else
        frame(h, s, m, 3);
`endif
      end
    end

    repeat (10) @(posedge clk);
    #1;
    check("events_outstanding", 64'(exp_q.size()), 64'd0);
    check("rx_clear_count", 64'(n_clr), 64'(n_sent));
    check("final_setpoints", {RPM_L, RPM_R, RPM_ENABLE, DIR_L, DIR_R, DIR_ENABLE},
          {m_rpm[0], m_rpm[1], m_rpm[2], m_dir[0], m_dir[1], m_dir[2]});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
